// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial add/sub sequencer.
// Optional overflow flag is enabled with SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

  localparam int SA_WIDTH_DEFAULT = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_seq_bit1_adder.sv
// bit1_adder: single-bit full adder cell shared by the serial sequencer.
// Purely combinational.
module bit1_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ ci;
  assign c = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: WIDTH-cycle bit-serial add/subtract around one bit1_adder.
// Define SERIAL_ADD_OVF_EN to add the signed overflow output ovf.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state;
  sa_state_t        state_nx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             last;

  bit1_adder u_cell (
    .x (sh_a[0]),
    .y (sh_b[0]),
    .ci(cy),
    .s (s),
    .c (c)
  );

  assign last = (state == RUN) && (cnt == LAST);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sh_a <= a;
        sh_b <= b ^ {WIDTH{sub}};
        cy   <= sub;
        cnt  <= '0;
      end else if (state == RUN) begin
        sh_a   <= sh_a >> 1;
        sh_b   <= sh_b >> 1;
        result <= {s, result[WIDTH-1:1]};
        cy     <= c;
        // hold cnt at WIDTH-1 so it never wraps inside an operation
        if (!last) cnt <= cnt + 1'b1;
        if (last) cout <= c;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic cy_msb;

  always_ff @(posedge clk) begin
    if (rst) cy_msb <= 1'b0;
    else if (last) cy_msb <= cy;
  end

  // carry into MSB xor carry out of MSB, both held until the next op ends
  assign ovf = cy_msb ^ cout;
`endif

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add/subtract sequencer that drives a single `bit1_adder` instance across WIDTH clock cycles to produce a WIDTH-bit sum or difference. It serves as the area-minimal arithmetic path for the MIPS32 core's multi-cycle units and is started by a one-cycle `start` strobe. Completion is signalled by a one-cycle `done` pulse. Handshake is start/busy/done; operands are captured on start, so callers may change them immediately afterward.

## Interface
- `WIDTH`, 32: operand/result width in bits; minimum 2.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `start`  in  1  operation request; sampled only in IDLE.
- `sub`  in  1  0 = a+b, 1 = a−b (two's complement); sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result`/`cout` are valid while it is high and held afterwards.
- `result`  out  WIDTH  sum/difference.
- `cout`  out  1  final carry out; for sub, 1 = no borrow.
- `ovf`  out  1  signed overflow; only present with SERIAL_ADD_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + `start`=1:
  - Latch `a` into `sh_a` and `b ^ {WIDTH{sub}}` into `sh_b`.
  - Set carry register `cy` = `sub` and `cnt` = 0.
  - Go to RUN.
- IDLE + `start`=0: stay in IDLE.
- RUN, each cycle:
  - Adder inputs are `sh_a[0]`, `sh_b[0]`, `cy`.
  - Shift `sh_a`/`sh_b` right by one.
  - Shift sum bit `s` into `result` MSB, with `result` shifting right.
  - `cy` ← adder `c`.
  - `cnt` ← `cnt`+1.
  - On the cycle where `cnt`==WIDTH−1: `cout` ← `c` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` in RUN or DONE is ignored, not queued, and has no effect on the operation in flight.
- `result` and `cout` keep their last values until the next accepted start.
  - During RUN, `result` holds partial shifted data and is not valid.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- `cnt` width is `$clog2(WIDTH)`; it never wraps within an operation.
- Reset values: state=IDLE; `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0; internal registers cleared.
- Reset mid-operation aborts the operation with no `done` pulse. `start` asserted in the same cycle as `rst` is ignored.

## Timing
- Edge E0 samples `start`.
- Edges E1..E(WIDTH) process bits 0..WIDTH−1.
- After edge E(WIDTH), `done`=1 and `result` is valid.
- At E(WIDTH+1), `done` falls and `busy` falls.
- Latency is WIDTH cycles from the start edge to `done`. Throughput is one operation per WIDTH+2 cycles; the earliest next start is sampled at E(WIDTH+1) or later in IDLE.
- `busy` rises after E0. `busy` is 0 exactly in the cycles where a start would be accepted.
- All outputs are registered except none; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Adds port `ovf` and a register `cy_msb` that captures the carry into the MSB, i.e. `cy` at the last RUN cycle.
  - `ovf` ← `cy_msb ^ c` at the transition to DONE; it is held like `result` and cleared by reset.
- `SERIAL_ADD_OVF_EN` undefined: no `ovf` port and no extra flops; all other behaviour is identical.

## Structure
- Package `serial_add_pkg` holds:
  - State enum `sa_state_t` {IDLE, RUN, DONE}.
  - `SA_WIDTH_DEFAULT`=32.
  - A `CNT_W` function/constant derived from WIDTH.
- One sub-module: the existing `bit1_adder`, instantiated once as the combinational bit cell. Everything else is FSM and shift registers in `serial_add_seq`.

## Test plan
- a=5, b=3, sub=0 → `done` exactly 32 cycles after start edge; `result`=8, `cout`=0; `busy` high 33 cycles.
- a=5, b=3, sub=1 → `result`=2, `cout`=1; then a=3, b=5, sub=1 → `result`=0xFFFFFFFE, `cout`=0.
- a=0xFFFFFFFF, b=1, sub=0 → `result`=0, `cout`=1, `ovf`=0 (with macro); a=0x7FFFFFFF, b=1 → `result`=0x80000000, `ovf`=1, `cout`=0.
- start a=1, b=1; re-pulse `start` with a=100, b=100 at cycles 5 and 32 → single `done`, `result`=2; next start in IDLE accepted normally.
- `rst` asserted at RUN cycle 10 → next cycle `busy`=0, `result`=0, no `done`; subsequent 7+9 → `result`=16.
- Back-to-back: start asserted continuously → operations accepted every 34 cycles, each `done` exactly one cycle wide.
